mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin multi-master arbiter onto one handshaked memory port
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN (bus timeout with m_err reporting).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   m_req      in   per-master request level
//   m_rw       in   per-master direction, 1 = write
//   m_addr     in   flat per-master address, master i at [i*ADDR_W +: ADDR_W]
//   m_wdata    in   flat per-master write data, master i at [i*DATA_W +: DATA_W]
//   m_rdata    out  shared registered read data, valid with m_ack
//   m_ack      out  one-hot completion pulse
//   m_err      out  one-hot timeout pulse, coincident with m_ack
//   mem_req    out  memory request level
//   mem_rw     out  memory direction, 1 = write
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, sampled with mem_ack
//   mem_ack    in   memory completion
//   busy       out  high while a transaction is in ACCESS or DONE
module mem_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_rw,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic                          mem_req,
    output logic                          mem_rw,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack,
    output logic                          busy
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           last_q, last_d;
    logic [GW-1:0]           gnt_q, gnt_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;
    logic [NUM_MASTERS-1:0]  m_ack_q, m_ack_d;
    logic [NUM_MASTERS-1:0]  m_err_q, m_err_d;
    logic                    busy_q, busy_d;

    logic [GW-1:0]           win_hi, win_lo, win;
    logic                    hi_vld, any_req;
    logic                    sel_rw;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic [NUM_MASTERS-1:0]  gnt_oh;
    logic                    timeout;

    // Round-robin: lowest requester above last wins; if none, wrap to the
    // lowest requester overall. Descending scan leaves the lowest index last.
    always_comb begin
        win_hi  = '0;
        win_lo  = '0;
        hi_vld  = 1'b0;
        any_req = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                win_lo  = GW'(i);
                any_req = 1'b1;
                if (i > int'(last_q)) begin
                    win_hi = GW'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        win = hi_vld ? win_hi : win_lo;
    end

    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (GW'(i) == win) begin
                sel_rw    = m_rw[i];
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            gnt_oh[i] = (GW'(i) == gnt_q);
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // cnt_q counts ACCESS cycles already spent without mem_ack, so the
    // TIMEOUT_CYCLES-th silent cycle is the one where cnt_q == TIMEOUT_CYCLES-1.
    logic [7:0] cnt_q, cnt_d;
    assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        mem_req_d   = mem_req_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        m_rdata_d   = m_rdata_q;
        m_ack_d     = '0;
        m_err_d     = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d       = win;
                    last_d      = win;
                    mem_req_d   = 1'b1;
                    mem_rw_d    = sel_rw;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = S_ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end
            end
            S_ACCESS: begin
                // mem_ack takes priority over a simultaneous timeout.
                if (mem_ack) begin
                    if (!mem_rw_q) begin
                        m_rdata_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    m_ack_d   = gnt_oh;
                    state_d   = S_DONE;
                end else if (timeout) begin
                    if (!mem_rw_q) begin
                        m_rdata_d = '1;
                    end
                    mem_req_d = 1'b0;
                    m_ack_d   = gnt_oh;
                    m_err_d   = gnt_oh;
                    state_d   = S_DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            last_q      <= LAST_RST;
            gnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m_rdata_q   <= '0;
            m_ack_q     <= '0;
            m_err_q     <= '0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            m_rdata_q   <= m_rdata_d;
            m_ack_q     <= m_ack_d;
            m_err_q     <= m_err_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign m_rdata   = m_rdata_q;
    assign m_ack     = m_ack_q;
    assign m_err     = m_err_q;
    assign mem_req   = mem_req_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int NM  = 2;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NM-1:0]     m_req, m_rw;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wdata;
    logic [DW-1:0]     m_rdata;
    logic [NM-1:0]     m_ack, m_err;
    logic              mem_req, mem_rw;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata, mem_rdata;
    logic              mem_ack, busy;

    int          errors = 0;
    int          checks = 0;
    int          exp_last;
    logic [31:0] exp_rdata;

    typedef struct {
        int          master;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdv;
        int          waits;
        bit          drop_mid;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_ack;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_MASTERS(NM), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit rw, input logic [31:0] a, input logic [31:0] d);
        m_req[i]             = 1'b1;
        m_rw[i]              = rw;
        m_addr[i*AW +: AW]   = a;
        m_wdata[i*DW +: DW]  = d;
    endtask

    // Winner = first requester found walking upward from last+1 modulo NM.
    function automatic int predict(input logic [NM-1:0] r, input int last);
        for (int k = 1; k <= NM; k++) begin
            int idx;
            idx = (last + k) % NM;
            if (((r >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    // Called at a negedge in IDLE with requests already driven.
    task automatic transact(input int waits, input logic [31:0] rdv, input bit drop_mid,
                            output int g, output logic [NM-1:0] ack_seen,
                            output logic [31:0] rd_seen);
        bit          e_rw;
        logic [31:0] e_addr, e_wd;
        logic [NM-1:0] oh;
        g = predict(m_req, exp_last);
        if (g < 0) begin
            chk("no_request_to_grant", 64'd0, 64'd1);
            ack_seen = '0;
            rd_seen  = '0;
            return;
        end
        e_rw   = m_rw[g];
        e_addr = m_addr[g*AW +: AW];
        e_wd   = m_wdata[g*DW +: DW];
        oh     = '0;
        oh[g]  = 1'b1;
        tick();
        chk("acc_mem_req", mem_req, 1);
        chk("acc_busy", busy, 1);
        chk("acc_mem_addr", mem_addr, e_addr);
        chk("acc_mem_wdata", mem_wdata, e_wd);
        chk("acc_mem_rw", mem_rw, e_rw);
        chk("acc_m_ack", m_ack, 0);
        if (drop_mid) begin
            m_addr[g*AW +: AW]  = ~e_addr;
            m_wdata[g*DW +: DW] = ~e_wd;
            m_req[g]            = 1'b0;
        end
        for (int w = 0; w < waits; w++) begin
            tick();
            chk("wait_mem_req", mem_req, 1);
            chk("wait_mem_addr", mem_addr, e_addr);
            chk("wait_mem_wdata", mem_wdata, e_wd);
            chk("wait_mem_rw", mem_rw, e_rw);
            chk("wait_m_ack", m_ack, 0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdv;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (!e_rw) exp_rdata = rdv;
        chk("done_m_ack", m_ack, oh);
        chk("done_m_err", m_err, 0);
        chk("done_mem_req", mem_req, 0);
        chk("done_busy", busy, 1);
        chk("done_m_rdata", m_rdata, exp_rdata);
        ack_seen = m_ack;
        rd_seen  = m_rdata;
        m_req[g] = 1'b0;
        exp_last = g;
        tick();
        chk("idle_m_ack", m_ack, 0);
        chk("idle_busy", busy, 0);
        chk("idle_mem_req", mem_req, 0);
    endtask

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(m_ack)) begin
            errors++;
            $display("FAIL ack_onehot: got %b expected at most one bit", m_ack);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          g;
        logic [NM-1:0] a;
        logic [31:0] r;
        int          order[3];

        vecs[0] = '{0, 1'b0, 32'h100,      32'h0,        32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 2'b01};
        vecs[1] = '{1, 1'b1, 32'h20,       32'h55AA,     32'h12345678, 3, 1'b0, 32'hDEADBEEF, 2'b10};
        vecs[2] = '{1, 1'b0, 32'h44,       32'h0,        32'hCAFEF00D, 1, 1'b0, 32'hCAFEF00D, 2'b10};
        vecs[3] = '{0, 1'b1, 32'h8,        32'hA5A5A5A5, 32'h0,        2, 1'b1, 32'hCAFEF00D, 2'b01};
        vecs[4] = '{0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h00000001, 0, 1'b1, 32'h00000001, 2'b01};
        order   = '{0, 1, 0};

        reset = 1'b0; m_req = '0; m_rw = '0; m_addr = '0; m_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        exp_last = NM - 1; exp_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_m_ack", m_ack, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_rw", mem_rw, 0);
        reset = 1'b1;
        tick();
        chk("idle_no_req", mem_req, 0);

        for (int t = 0; t < 5; t++) begin
            set_req(vecs[t].master, vecs[t].rw, vecs[t].addr, vecs[t].wdata);
            transact(vecs[t].waits, vecs[t].rdv, vecs[t].drop_mid, g, a, r);
            chk("vec_grant", g, vecs[t].master);
            chk("vec_ack", a, vecs[t].exp_ack);
            chk("vec_rdata", r, vecs[t].exp_rdata);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        set_req(1, 1'b0, 32'h300, 32'h0);
        for (int c = 0; c < TMO; c++) begin
            tick();
            chk("tmo_mem_req", mem_req, 1);
            chk("tmo_m_ack", m_ack, 0);
        end
        tick();
        exp_rdata = 32'hFFFFFFFF;
        chk("tmo_ack", m_ack, 2'b10);
        chk("tmo_err", m_err, 2'b10);
        chk("tmo_mem_req_low", mem_req, 0);
        chk("tmo_rdata", m_rdata, 32'hFFFFFFFF);
        m_req = '0;
        exp_last = 1;
        tick();
        chk("tmo_err_clr", m_err, 0);
        set_req(0, 1'b0, 32'h304, 32'h0);
        transact(TMO - 1, 32'h0BADF00D, 1'b0, g, a, r);
        chk("tmo_ack_wins", r, 32'h0BADF00D);
`endif

        set_req(1, 1'b0, 32'h500, 32'h0);
        tick();
        chk("rmid_mem_req", mem_req, 1);
        #1 reset = 1'b0;
        #1;
        chk("rmid_mem_req_drop", mem_req, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_m_ack", m_ack, 0);
        chk("rmid_m_rdata", m_rdata, 0);
        m_req = '0;
        tick();
        chk("rmid_no_ack", m_ack, 0);
        reset = 1'b1;
        exp_last = NM - 1;
        exp_rdata = '0;
        tick();

        set_req(0, 1'b0, 32'h600, 32'h0);
        set_req(1, 1'b0, 32'h700, 32'h0);
        for (int k = 0; k < 3; k++) begin
            transact(k, 32'h1000 + k, 1'b0, g, a, r);
            chk("rr_order", g, order[k]);
            set_req(g, 1'b0, 32'h600 + 32'(g) * 32'h100, 32'h0);
        end
        transact(0, 32'h2000, 1'b0, g, a, r);
        chk("rr_order_tail", g, 1);
        if (m_req != '0) transact(0, 32'h2001, 1'b0, g, a, r);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NM; i++) begin
                if (!m_req[i] && ($urandom_range(0, 1) == 1))
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            if (m_req == '0)
                set_req(int'($urandom_range(0, NM - 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            transact(int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0), g, a, r);
        end
        while (m_req != '0) transact(0, $urandom, 1'b0, g, a, r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
